// File: rtl/segment_scan_driver.sv
// segment_scan_driver: time-multiplexed 7-segment (+ tens-indicator pair) scan driver.
//   Scans NUM_DIGITS digits, DIV clock cycles per digit slot, with registered segment and
//   anode outputs (one cycle behind the scan state), a blanked first cycle in every slot to
//   hide ghosting, optional leading-zero blanking and a double-buffered digit load.
// Optional feature: define SEG_BLINK_EN to add the blink input and the blink phase logic.
// Ports:
//   clk, rst_n      clock (rising edge) and synchronous active-low reset
//   digits_i        packed digit codes, nibble k = digit k (digit 0 least significant)
//   load_valid      digits_i offered; load_ready high when the pending buffer is free
//   blank_lz        leading-zero blanking enable, sampled every cycle
//   blink           (SEG_BLINK_EN only) blink enable
//   segments        bit0=a .. bit5=f, bit6=g, bits8:7 tens-indicator pair, active high
//   an_n            active-low digit enables, one-hot-low or all ones
//   frame_done      one-cycle pulse in the last cycle of the last digit slot
module segment_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIV          = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    blank_lz,
`ifdef SEG_BLINK_EN
  input  logic                    blink,
`endif
  output logic [8:0]              segments,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   active;
  logic [4*NUM_DIGITS-1:0]   pending;
  logic                      pending_full;
  logic                      slot_last;
  logic                      idx_last;

  logic [3:0]                cur_code;
  logic                      cur_lz;
  logic                      zero_run;
  logic                      blink_off;
  logic                      blank_slot;

  function automatic logic [8:0] decode(input logic [3:0] code);
    logic [8:0] pat;
    case (code)
      4'd0:    pat = 9'b000111111;
      4'd1:    pat = 9'b000000110;
      4'd2:    pat = 9'b001011011;
      4'd3:    pat = 9'b001001111;
      4'd4:    pat = 9'b001100110;
      4'd5:    pat = 9'b001101101;
      4'd6:    pat = 9'b001111101;
      4'd7:    pat = 9'b000000111;
      4'd8:    pat = 9'b001111111;
      4'd9:    pat = 9'b001100111;
      4'd10:   pat = 9'b110111111;  // "10": indicator pair plus a zero
      4'd11:   pat = 9'b110000110;  // "11": indicator pair plus a one
      default: pat = 9'b000000000;
    endcase
    return pat;
  endfunction

  assign slot_last  = (cnt == CNT_MAX);
  assign idx_last   = (idx == IDX_MAX);
  assign frame_done = slot_last && idx_last;
  assign load_ready = ~pending_full;

  // Slot counter and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_last) begin
      cnt <= '0;
      idx <= idx_last ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Double buffer: a new set waits in pending and only reaches the display at a
  // frame boundary, so a frame never mixes old and new digits. Ready is simply
  // "pending is empty", so a capture and a commit can never coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
    end else begin
      if (frame_done && pending_full) begin
        active       <= pending;
        pending_full <= 1'b0;
      end
      if (load_valid && load_ready) begin
        pending      <= digits_i;
        pending_full <= 1'b1;
      end
    end
  end

  // Select the current digit; zero_run accumulates "this and every higher digit is
  // zero" while walking from the most significant digit downwards.
  always_comb begin
    cur_code = '0;
    cur_lz   = 1'b0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (active[4*k +: 4] == 4'd0);
      if (idx == IW'(k)) begin
        cur_code = active[4*k +: 4];
        cur_lz   = (k != 0) && zero_run;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frm_cnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else if (!blink) begin
      frm_cnt <= '0;
      phase   <= 1'b0;
    end else if (frame_done) begin
      if (frm_cnt == FRM_MAX) begin
        frm_cnt <= '0;
        phase   <= ~phase;
      end else begin
        frm_cnt <= frm_cnt + FW'(1);
      end
    end
  end

  assign blink_off = blink && phase;
`else
  assign blink_off = 1'b0;
`endif

  // Slot count 0 is always dark so the anode switch never shows the previous digit.
  assign blank_slot = (cnt == '0) || (blank_lz && cur_lz) || blink_off;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      segments <= '0;
      an_n     <= '1;
    end else if (blank_slot) begin
      segments <= '0;
      an_n     <= '1;
    end else begin
      segments <= decode(cur_code);
      an_n     <= ~(NUM_DIGITS'(1) << idx);
    end
  end

endmodule

// File: doc/segment_scan_driver.md
SEGMENT_SCAN_DRIVER -- requirements
Module: segment_scan_driver

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, 1..8.
REQ-002 Parameter DIV, default 1000: clock cycles per digit slot, >= 2.
REQ-003 Parameter BLINK_FRAMES, default 64: scan frames per blink phase, >= 1.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 digits_i  in  4*NUM_DIGITS  packed digit codes; nibble k = digit k, digit 0 least significant.
REQ-007 load_valid  in  1  digits_i is offered for capture.
REQ-008 load_ready  out  1  block can accept a new digit set.
REQ-009 blank_lz  in  1  leading-zero blanking enable, sampled every cycle.
REQ-010 blink  in  1  blink enable; present only when SEG_BLINK_EN is defined.
REQ-011 segments  out  9  active-high pattern, bit0=a .. bit5=f, bit6=g, bits8:7=tens-indicator pair.
REQ-012 an_n  out  NUM_DIGITS  active-low digit enables, one-hot-low or all ones.
REQ-013 frame_done  out  1  single-cycle pulse at end of last digit slot.

Function
REQ-014 Decode: 0=000111111, 1=000000110, 2=001011011, 3=001001111, 4=001100110, 5=001101101, 6=001111101, 7=000000111, 8=001111111, 9=001100111, 10=110111111, 11=110000110, 12..15=000000000.
REQ-015 Slot counter counts 0..DIV-1; at DIV-1 it wraps to 0 and digit index advances, NUM_DIGITS-1 wrapping to 0.
REQ-016 frame_done shall pulse on the cycle slot counter = DIV-1 and index = NUM_DIGITS-1.
REQ-017 segments and an_n shall be registered, reflecting slot counter/index with exactly one cycle latency.
REQ-018 Ghost guard: for slot counter = 0, registered output is an_n all ones, segments 0.
REQ-019 Otherwise an_n bit for current index is 0, all other bits 1; segments = decode of the active-register nibble at current index.
REQ-020 Handshake: transfer when load_valid and load_ready are both high; digits_i captured into a pending register; load_ready drops the next cycle.
REQ-021 Pending copied to active register on the frame_done cycle; load_ready returns high the following cycle.
REQ-022 load_valid while load_ready low is ignored; no capture, no state change.
REQ-023 Transfer on the frame_done cycle while ready high: captured to pending, committed at the next frame_done, not the current one.
REQ-024 Leading-zero blanking, blank_lz=1: digit k>0 is blanked when it and every higher digit equal 0; digit 0 is never blanked; only code 0 counts as zero.
REQ-025 Blanked slot: an_n all ones, segments 0; slot timing unchanged.

Reset
REQ-026 While rst_n=0 at a clock edge: segments=0, an_n all ones, frame_done=0, load_ready=1, slot counter=0, index=0, active and pending registers all 0, blink state cleared.
REQ-027 Reset mid-frame or mid-pending shall discard the pending set; scanning restarts at slot 0 of digit 0 on the first cycle after release.

Configuration
REQ-028 Macro SEG_BLINK_EN defined: blink port, frame counter 0..BLINK_FRAMES-1 and phase bit exist; phase toggles when the counter wraps at frame_done.
REQ-029 With SEG_BLINK_EN, blink=1 and phase=1 force an_n all ones and segments 0; blink=0 forces phase to 0 and counter to 0.
REQ-030 Without SEG_BLINK_EN: no blink port, no blink logic; display never suppressed except by REQ-018/REQ-025.

Verification (NUM_DIGITS=4, DIV=4, BLINK_FRAMES=2)
REQ-031 Reset held 3 cycles -> segments=0, an_n=1111, load_ready=1, frame_done=0; first frame_done 16 cycles after release.
REQ-032 Load 16'h3210 -> after next frame_done, slot 0 segments=000111111 an_n=1110, slot 1 000000110 an_n=1101, slot 2 001011011 an_n=1011, slot 3 001001111 an_n=0111; slot counter=0 cycles all blank.
REQ-033 Load 16'h0007, blank_lz=1 -> slots 3,2,1 an_n=1111 segments=0; slot 0 segments=000000111 an_n=1110; blank_lz=0 -> slots 3..1 show 000111111.
REQ-034 Load 16'hEBA0 -> slot 1 110111111, slot 2 110000110, slot 3 000000000 with an_n=0111; second load_valid while ready low is ignored until frame_done+1.
REQ-035 Transfer coincident with frame_done -> display unchanged for one frame, new value on following frame.
REQ-036 SEG_BLINK_EN, blink=1 -> 2 frames normal, 2 frames an_n=1111, repeating; rst_n=0 mid-frame -> outputs reset value next cycle, pending discarded.
